// File: rtl/amstrad_asic_pri.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | amstrad_asic_pri : Plus-mode ASIC programmable raster interrupt          |
// | Optional IM2 vector register enabled by macro ASIC_PRI_VECTOR_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module amstrad_asic_pri #(
   parameter int          LINE_W   = 8,
   parameter logic [15:0] PRI_ADDR = 16'h6800,
   parameter logic [15:0] IVR_ADDR = 16'h6805
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              asic_sel,
   input  logic [15:0]       A,
   input  logic [7:0]        D,
   input  logic              mem_wr,
   input  logic              m1,
   input  logic              iorq,
   input  logic              hsync,
   input  logic              vsync,
   output logic              pri_irq,
   output logic              ga_int_mask,
   output logic [7:0]        int_vector,
   output logic [LINE_W-1:0] line_count
);

   logic              r_hs_old;
   logic              r_vs_old;
   logic              r_sync_primed;
   logic              r_wr_old;
   logic              r_ack_old;
   logic              r_bus_primed;
   logic [LINE_W-1:0] r_pri;
   logic [LINE_W-1:0] r_line;
   logic              r_pending;
   logic              r_mask;

   logic              w_hs_rise;
   logic              w_vs_rise;
   logic              w_wr;
   logic              w_wr_rise;
   logic              w_ack_rise;
   logic              w_pri_wr;
   logic [LINE_W:0]   w_line_inc;
   logic              w_match;

   // Primed flags keep the first level seen after reset from looking like an edge.
   assign w_hs_rise  = ce & hsync & ~r_hs_old & r_sync_primed;
   assign w_vs_rise  = ce & vsync & ~r_vs_old & r_sync_primed;
   assign w_wr       = mem_wr & asic_sel;
   assign w_wr_rise  = w_wr & ~r_wr_old & r_bus_primed;
   assign w_ack_rise = m1 & iorq & ~r_ack_old & r_bus_primed;
   assign w_pri_wr   = w_wr_rise & (A == PRI_ADDR);

   // One extra bit so a saturated counter can never alias onto a programmed line.
   assign w_line_inc = {1'b0, r_line} + 1'b1;
   assign w_match    = w_hs_rise & ~w_vs_rise & (r_pri != '0) & (w_line_inc == {1'b0, r_pri});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hs_old      <= 1'b0;
         r_vs_old      <= 1'b0;
         r_sync_primed <= 1'b0;
         r_wr_old      <= 1'b0;
         r_ack_old     <= 1'b0;
         r_bus_primed  <= 1'b0;
         r_pri         <= '0;
         r_line        <= '0;
         r_pending     <= 1'b0;
         r_mask        <= 1'b0;
      end else begin
         if (ce) begin
            r_hs_old      <= hsync;
            r_vs_old      <= vsync;
            r_sync_primed <= 1'b1;
         end
         r_wr_old     <= w_wr;
         r_ack_old    <= m1 & iorq;
         r_bus_primed <= 1'b1;

         if (w_vs_rise)
            r_line <= '0;
         else if (w_hs_rise && !(&r_line))
            r_line <= r_line + 1'b1;

         if (w_pri_wr)
            r_pri <= LINE_W'(D);

         r_mask <= (r_pri != '0) & asic_sel;

         // A match wins over both clearing sources in the same cycle.
         if (w_match)
            r_pending <= 1'b1;
         else if (w_pri_wr && (D == 8'h00))
            r_pending <= 1'b0;
         else if (w_ack_rise && r_pending)
            r_pending <= 1'b0;
      end
   end

   assign pri_irq     = r_pending;
   assign ga_int_mask = r_mask;
   assign line_count  = r_line;

`ifdef ASIC_PRI_VECTOR_EN
   logic       w_ivr_wr;
   logic [4:0] r_ivr;
   logic [7:0] r_vec;

   assign w_ivr_wr = w_wr_rise & (A == IVR_ADDR);

   // The vector only follows the IVR while idle, so it is frozen across an acknowledge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ivr <= 5'd0;
         r_vec <= 8'h06;
      end else begin
         if (w_ivr_wr)
            r_ivr <= D[7:3];
         if (!r_pending)
            r_vec <= {r_ivr, 3'b110};
      end
   end

   assign int_vector = r_vec;
`else
   assign int_vector = 8'hFF;
`endif

endmodule
`default_nettype wire
